// File: rtl/pixel_writer.sv
// Generic FIFO with synchronous flush; the head is readable combinationally and a push shows up there one cycle later.
// No internal overflow guard: the owner must never push when full or pop when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_q[AW-1:0]];
    assign empty_o    = (wr_q == rd_q);
endmodule

// Clips (x, y) pixels to the frame and writes in-frame ones to a linear framebuffer port.
// One registered address stage feeds the FIFO; in_ready reflects a registered full flag that counts the stage too.
module pixel_writer #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int ADDR_W     = 17,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               _clock,
    input  logic               _reset_n,
    input  logic               _start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_x,
    input  logic [31:0]        in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_done,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ready,
    output logic [15:0]        pixels_written,
    output logic [15:0]        pixels_clipped,
    output logic               _done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int                 OW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]        W32     = 32'(FB_WIDTH);
    localparam logic [31:0]        H32     = 32'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0]  WA      = ADDR_W'(FB_WIDTH);
    localparam logic [OW-1:0]      OCC_MAX = OW'(FIFO_DEPTH);

    state_t               state_q, state_d;
    logic [OW-1:0]        occ_q, occ_d;
    logic                 full_q, full_d;
    logic                 stg_vld_q, stg_vld_d;
    logic [ADDR_W-1:0]    stg_addr_q, stg_addr_d;
    logic [COLOR_W-1:0]   stg_col_q;
    logic [15:0]          wr_cnt_q, wr_cnt_d;
    logic [15:0]          clip_cnt_q, clip_cnt_d;
    logic                 accept, clip, pop, fifo_empty;
    logic [ADDR_W+COLOR_W-1:0] head;

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (_start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (in_done) state_d = DRAIN;
                // occ_q covers both the address stage and the FIFO
                DRAIN:   if (occ_q == '0) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        _done    = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = !full_q;
                mem_we   = !fifo_empty;
            end
            DRAIN:   mem_we = !fifo_empty;
            DONE:    _done  = 1'b1;
            default: ;
        endcase
    end

    assign accept     = in_valid && in_ready && !_start;
    assign clip       = (in_x >= W32) || (in_y >= H32);
    assign pop        = mem_we && mem_ready && !_start;
    assign stg_vld_d  = accept && !clip;
    assign stg_addr_d = in_y[ADDR_W-1:0] * WA + in_x[ADDR_W-1:0];

    always_comb begin
        occ_d      = occ_q + OW'(stg_vld_d) - OW'(pop);
        wr_cnt_d   = wr_cnt_q;
        clip_cnt_d = clip_cnt_q;
        if (pop && wr_cnt_q != 16'hFFFF)                 wr_cnt_d   = wr_cnt_q + 16'd1;
        if (accept && clip && clip_cnt_q != 16'hFFFF)    clip_cnt_d = clip_cnt_q + 16'd1;
        if (_start) begin
            occ_d      = '0;
            wr_cnt_d   = '0;
            clip_cnt_d = '0;
        end
        full_d = (occ_d == OCC_MAX);
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            occ_q      <= '0;
            full_q     <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_col_q  <= '0;
            wr_cnt_q   <= '0;
            clip_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            full_q     <= full_d;
            stg_vld_q  <= stg_vld_d;
            stg_addr_q <= stg_addr_d;
            stg_col_q  <= in_color;
            wr_cnt_q   <= wr_cnt_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    fifo #(.W(ADDR_W + COLOR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (_clock),
        .rst_n      (_reset_n),
        .flush_i    (_start),
        .push_i     (stg_vld_q && !_start),
        .push_dat_i ({stg_addr_q, stg_col_q}),
        .pop_i      (pop),
        .head_dat_o (head),
        .empty_o    (fifo_empty)
    );

    // Gated so the port reads zero whenever no write is being requested
    assign mem_addr       = mem_we ? head[ADDR_W+COLOR_W-1:COLOR_W] : '0;
    assign mem_data       = mem_we ? head[COLOR_W-1:0] : '0;
    assign pixels_written = wr_cnt_q;
    assign pixels_clipped = clip_cnt_q;
endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Downstream consumer of the rectangle/shape coordinate generators: takes their (x, y) pixel stream plus a colour and writes each pixel into a linear framebuffer memory port.
- Clips coordinates outside the frame and converts in-frame coordinates to a linear address.
- Decouples generator and memory through a small FIFO.
- Reports per-session counts of written and clipped pixels, and signals completion once the upstream generator is done and all accepted pixels have been written.

Parameters:
- FB_WIDTH, 320, frame width in pixels.
- FB_HEIGHT, 240, frame height in pixels.
- ADDR_W, 17, memory address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT.
- COLOR_W, 8, pixel data width.
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, >= 2.

Ports:
- _clock  in  1  rising-edge clock.
- _reset_n  in  1  asynchronous active-low reset.
- _start  in  1  one-cycle pulse; begins a new session.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_x  in  32  pixel x (upstream _out0).
- in_y  in  32  pixel y (upstream _out1).
- in_color  in  COLOR_W  pixel colour.
- in_done  in  1  upstream _done level.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  COLOR_W  write data.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- pixels_written  out  16  writes completed this session.
- pixels_clipped  out  16  pixels dropped by clipping this session.
- _done  out  1  session complete (sticky).

Behaviour:
- Reset (async, _reset_n=0):
  - State IDLE; FIFO empty.
  - in_ready=0, mem_we=0, mem_addr=0, mem_data=0, pixels_written=0, pixels_clipped=0, _done=0.
- States: IDLE, RUN, DRAIN, DONE.
- _start in any state: flush FIFO, zero both counters, _done<=0, next state RUN. _start overrides all other events in that cycle; no accept or pop occurs.
- RUN:
  - in_ready = !fifo_full (registered full flag).
  - No same-cycle pass-through: a pop does not free a slot until the next cycle.
- Accept path, on handshake:
  - x and y are compared unsigned against the full 32 bits, so negative coordinates clip.
  - If x >= FB_WIDTH or y >= FB_HEIGHT: pixel dropped, pixels_clipped+1.
  - Otherwise push {y*FB_WIDTH + x truncated to ADDR_W, in_color}.
- RUN -> DRAIN when in_done=1. A pixel handshaked in that same cycle is still processed.
- DRAIN: in_ready=0; DRAIN -> DONE when the FIFO is empty and no write is pending.
- DONE: _done=1, held until the next _start or reset. in_ready=0, mem_we=0.
- IDLE: in_ready=0, mem_we=0. in_valid and in_done are ignored.
- Write path (RUN and DRAIN):
  - mem_we = FIFO non-empty; mem_addr/mem_data present the FIFO head.
  - On mem_we && mem_ready: pop, pixels_written+1.
  - mem_addr/mem_data must stay stable while mem_we=1 and mem_ready=0.
  - Throughput is one write per cycle with mem_ready held high.
- Latency: in-frame pixel accepted at edge N with the FIFO empty → mem_we=1 with its address after edge N+1.
- Counters saturate at 16'hFFFF; no wrap.
- Simultaneous push and pop: occupancy unchanged. The slot freed by the pop is not visible to in_ready until the next cycle.
- Write order equals acceptance order.
- Multiplier: a single constant-width product, reaching mem_addr in no more than one pipeline stage.

Test Plan:
- Reset then _start; 2x3 rectangle at (10,20) with mem_ready=1:
  - Required writes: addresses 6410, 6411, 6730, 6731, 7050, 7051 (FB_WIDTH=320).
  - pixels_written=6, pixels_clipped=0; _done=1 within 2 cycles of in_done.
- Clipping: pixels (319,0), (320,0), (0,240), (0xFFFFFFFF,5):
  - Required: one write to addr 319; pixels_clipped=3.
- Back-pressure: mem_ready=0 while 5 pixels are offered:
  - in_ready falls after 4 accepts; mem_addr is stable throughout.
  - After releasing mem_ready, all 5 writes occur in order, and _done rises only after the last write.
- Simultaneous in_done and final handshake: that pixel is written and counted before _done=1.
- _start mid-session with 3 entries queued:
  - FIFO flushed, counters 0, state RUN, and none of the old entries are written.
- Async reset asserted mid-DRAIN between clock edges: all outputs are at reset values immediately, before the next edge.
